// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
//   N-to-1 round-robin arbiter for ready/valid payload channels. One registered
//   output stage gives 1-cycle latency at full throughput, and the index of the
//   producing requester travels alongside each beat.
//
// Parameters
//   N    number of requesters (N >= 2)
//   T    payload type (packed); reset value '0
//   IDW  width of the source index, $clog2(N)
//
// Ports
//   clk        in   1       clock, rising edge
//   reset_n    in   1       asynchronous reset, active low
//   valid_in   in   N       per-requester valid
//   ready_in   out  N       per-requester ready, at most one bit set (combinational)
//   data_in    in   N x T   per-requester payload
//   lock_in    in   N       per-requester "more beats follow" flag
//   valid_out  out  1       output valid (registered)
//   ready_out  in   1       downstream ready
//   data_out   out  T       output payload (registered)
//   src_out    out  IDW     requester index of data_out (registered)
//
// Configuration
//   ARB_LOCK_EN  when defined, an accepted beat with lock_in[g]=1 locks the
//                grant to requester g until it sends a beat with lock_in=0.
//                When undefined, lock_in is ignored.
// -----------------------------------------------------------------------------
module rr_stream_arbiter #(
  parameter int  N   = 4,
  parameter type T   = logic,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   valid_in,
  output logic [N-1:0]   ready_in,
  input  T               data_in [N],
  input  logic [N-1:0]   lock_in,
  output logic           valid_out,
  input  logic           ready_out,
  output T               data_out,
  output logic [IDW-1:0] src_out
);

  // Output stage and round-robin pointer
  logic           r_vq;
  T               r_dq;
  logic [IDW-1:0] r_sq;
  logic [IDW-1:0] r_rr_ptr;

  // Arbitration wires
  logic [N-1:0]   w_req;
  logic           w_stage_free;
  logic           w_any;
  logic           w_accept;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_next_ptr;
  logic           w_hi_found;
  logic [IDW-1:0] w_hi_idx;
  logic           w_lo_found;
  logic [IDW-1:0] w_lo_idx;

`ifdef ARB_LOCK_EN
  logic           r_locked;
  logic [IDW-1:0] r_lock_id;
  logic [N-1:0]   w_lock_mask;

  assign w_lock_mask = {{(N-1){1'b0}}, 1'b1} << r_lock_id;
  // While locked, only the lock owner is eligible, even when it is idle.
  assign w_req       = r_locked ? (valid_in & w_lock_mask) : valid_in;
`else
  logic w_unused_lock;

  assign w_unused_lock = ^lock_in;
  assign w_req         = valid_in;
`endif

  // The stage can take a beat when empty or when its beat leaves this cycle.
  assign w_stage_free = ~r_vq | ready_out;

  // Rotating priority search: the lowest requester at or above r_rr_ptr wins;
  // if none exists, the lowest requester overall wins (wrap-around).
  // Scanning downward lets the last overwrite leave the lowest index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_lo_found = w_lo_found | w_req[i];
      w_lo_idx   = w_req[i] ? IDW'(i) : w_lo_idx;
      w_hi_found = w_hi_found | (w_req[i] & (i >= int'(r_rr_ptr)));
      w_hi_idx   = (w_req[i] && (i >= int'(r_rr_ptr))) ? IDW'(i) : w_hi_idx;
    end
  end

  assign w_gnt      = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_any      = w_lo_found;
  assign w_accept   = w_any & w_stage_free;
  assign w_next_ptr = (w_gnt == IDW'(N - 1)) ? '0 : (w_gnt + IDW'(1));

  // One-hot ready to the granted requester; forced low while in reset.
  always_comb begin
    ready_in = '0;
    if (w_accept && reset_n) begin
      ready_in[w_gnt] = 1'b1;
    end else begin
      ready_in = '0;
    end
  end

  // Output stage: load on accept (also covers drain+accept), else drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vq <= 1'b0;
      r_dq <= '0;
      r_sq <= '0;
    end else if (w_accept) begin
      r_vq <= 1'b1;
      r_dq <= data_in[w_gnt];
      r_sq <= w_gnt;
    end else if (ready_out) begin
      r_vq <= 1'b0;
    end else begin
      r_vq <= r_vq;
    end
  end

`ifdef ARB_LOCK_EN
  // Pointer and lock state: a locking beat holds the pointer; the closing
  // beat of a packet releases the lock and moves past the owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr  <= '0;
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_accept) begin
      if (lock_in[w_gnt]) begin
        r_locked  <= 1'b1;
        r_lock_id <= w_gnt;
      end else begin
        r_locked  <= 1'b0;
        r_rr_ptr  <= w_next_ptr;
      end
    end else begin
      r_locked <= r_locked;
    end
  end
`else
  // Pointer advances past every granted requester; idle cycles leave it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign valid_out = r_vq;
  assign data_out  = r_dq;
  assign src_out   = r_sq;

endmodule
